fetch_agu: RTL and testbench
============================

Name: fetch_agu

Overview:
- Responder to the control unit's strobe outputs: owns the PC, performs instruction-memory fetches, and returns the instruction word on `ir`.
- Also owns the MAR and the row/column address counters driven by the CU's mar_inc, col_inc, row_inc and col_zero.
- Sits between the CU, instruction memory and data memory; `ir` feeds the CU's `ir` input, and `dmem_addr` feeds data memory.

Parameters:
- BUS_WIDTH, 16, instruction/operand word width
- PC_WIDTH, 8, program counter and imem address width
- MAR_WIDTH, 8, memory address register width
- ROWS, 16, row counter modulus (row range 0..ROWS-1)
- COLS, 16, column counter modulus (col range 0..COLS-1)
- FETCH_TIMEOUT, 15, maximum wait cycles for imem_ack (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cu_reset  in  1  synchronous active-high clear from the CU
- imem_read  in  1  fetch strobe
- pc_inc  in  1  PC increment strobe
- jump  in  1  conditional jump strobe
- alu_zero  in  1  ALU zero flag, sampled on the jump edge
- mar_inc  in  1  MAR increment strobe
- col_inc  in  1  column increment strobe
- row_inc  in  1  row increment strobe
- col_zero  in  1  column clear, level-sensitive
- imem_req  out  1  fetch request to imem
- imem_addr  out  PC_WIDTH  fetch address, held stable while imem_req=1
- imem_rdata  in  BUS_WIDTH  imem data, valid when imem_ack=1
- imem_ack  in  1  one-cycle completion from imem
- ir  out  BUS_WIDTH  latched instruction word
- operand  out  BUS_WIDTH  latched operand/immediate word
- pc  out  PC_WIDTH  current program counter
- mar  out  MAR_WIDTH  memory address register
- row  out  clog2(ROWS)  row counter
- col  out  clog2(COLS)  column counter
- dmem_addr  out  clog2(ROWS*COLS)  row*COLS+col, combinational from the row/col registers
- busy  out  1  fetch outstanding
- fetch_err  out  1  sticky error flag

Behaviour:
- Reset values (reset_n=0 asynchronously, or cu_reset=1 synchronously): every register and output is 0.
  - This includes pc, ir, operand, mar, row, col, imem_req, busy, fetch_err, the FSM state and the previous-value strobe registers.
  - cu_reset has priority over every other input.
- Strobe handling:
  - imem_read, pc_inc, jump, mar_inc, col_inc and row_inc act only on a rising edge: current value 1, previous-cycle value 0.
  - A strobe held high for N cycles acts exactly once.
  - col_zero is level-sensitive.
- Fetch FSM has three states: IDLE, REQ, DONE.
  - IDLE -> REQ on an imem_read edge.
    - In that cycle, capture addr = pc, taken before any same-cycle pc update.
    - Set kind = INSTR if pc_inc is high (level) in that cycle; otherwise kind = OPER.
    - Assert imem_req and busy from the next cycle.
  - REQ:
    - Hold imem_req=1 and imem_addr.
    - On imem_ack=1: latch imem_rdata into ir (INSTR) or operand (OPER), drop imem_req, go to DONE.
  - DONE -> IDLE after one cycle; busy=0 in IDLE only.
  - An imem_read edge while not IDLE is ignored and sets fetch_err.
  - imem_ack while in IDLE is ignored.
- PC:
  - On a pc_inc edge: pc <= pc+1, wrapping modulo 2^PC_WIDTH (0xFF -> 0x00).
  - On a jump edge with alu_zero=0: pc <= operand[PC_WIDTH-1:0].
  - On a jump edge with alu_zero=1: pc unchanged (the jump is not taken).
  - Jump edge and pc_inc edge in the same cycle: the jump result wins (the increment is dropped only if the jump is taken).
- MAR: on a mar_inc edge, mar <= mar+1, wrapping modulo 2^MAR_WIDTH.
- Column counter:
  - col_zero=1 forces col <= 0; this has priority over a col_inc edge in the same cycle.
  - Otherwise, on a col_inc edge: col <= (col==COLS-1) ? 0 : col+1. Wrap does not carry into row.
- Row counter: on a row_inc edge, row <= (row==ROWS-1) ? 0 : row+1.
  - The CU's row_inc + col_zero pair gives row+1 and col=0 in the same cycle.
- Latency:
  - imem_req rises 1 cycle after the imem_read edge.
  - ir/operand update in the cycle after imem_ack.
  - Counter updates are visible 1 cycle after the strobe edge.
- Reset mid-fetch (either reset): return to IDLE, drop imem_req, discard any pending ack.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A wait counter runs in REQ.
  - If FETCH_TIMEOUT cycles elapse without imem_ack: abort to IDLE, drop imem_req, set fetch_err, leave ir/operand unchanged.
  - The counter clears on every entry to REQ.
- FETCH_TIMEOUT_EN undefined: REQ waits indefinitely; no counter logic is present.

Test Plan:
- INSTR fetch:
  - Stimulus: reset_n pulse, pc=0; imem_read and pc_inc both rise together; imem acks 2 cycles later with 0x2A5C.
  - Required: imem_addr=0x00 throughout REQ; pc=0x01; ir=0x2A5C; operand=0; busy returns to 0.
- OPER fetch then jump:
  - Stimulus: imem_read rises alone, ack data 0x0037; then jump rises with alu_zero=0.
  - Required: operand=0x0037; pc=0x37.
  - Repeat with alu_zero=1 -> pc unchanged.
- Held strobe:
  - Stimulus: pc_inc held high 3 cycles from pc=0xFF.
  - Required: pc=0x00 (single wrap); no further change.
- Matrix walk:
  - Stimulus: COLS=16; 15 col_inc edges, then row_inc + col_zero together.
  - Required: col=15, row=0, dmem_addr=15; then row=1, col=0, dmem_addr=16.
  - Also: col_inc edge + col_zero together -> col=0.
- Overlap and reset:
  - Stimulus: a second imem_read edge during REQ.
  - Required: fetch_err=1, still one request outstanding.
  - Then cu_reset=1 mid-REQ -> next cycle imem_req=0, pc=0, fetch_err=0.
- Timeout (FETCH_TIMEOUT_EN, FETCH_TIMEOUT=15):
  - Stimulus: no ack after the request.
  - Required: imem_req drops after 15 REQ cycles; fetch_err=1; ir unchanged.

Source files
------------

// File: rtl/fetch_agu.sv
// Fetch/address-generation unit: owns PC, IR/operand fetch FSM, MAR and row/col counters.
// Optional build macro FETCH_TIMEOUT_EN adds an imem_ack wait timeout in the REQ state.
module fetch_agu #(
   parameter int BUS_WIDTH = 16,
   parameter int PC_WIDTH  = 8,
   parameter int MAR_WIDTH = 8,
   parameter int ROWS      = 16,
   parameter int COLS      = 16
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int FETCH_TIMEOUT = 15
`endif
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           cu_reset,
   input  logic                           imem_read,
   input  logic                           pc_inc,
   input  logic                           jump,
   input  logic                           alu_zero,
   input  logic                           mar_inc,
   input  logic                           col_inc,
   input  logic                           row_inc,
   input  logic                           col_zero,
   output logic                           imem_req,
   output logic [PC_WIDTH-1:0]            imem_addr,
   input  logic [BUS_WIDTH-1:0]           imem_rdata,
   input  logic                           imem_ack,
   output logic [BUS_WIDTH-1:0]           ir,
   output logic [BUS_WIDTH-1:0]           operand,
   output logic [PC_WIDTH-1:0]            pc,
   output logic [MAR_WIDTH-1:0]           mar,
   output logic [$clog2(ROWS)-1:0]        row,
   output logic [$clog2(COLS)-1:0]        col,
   output logic [$clog2(ROWS*COLS)-1:0]   dmem_addr,
   output logic                           busy,
   output logic                           fetch_err
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int DA_W  = $clog2(ROWS*COLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   typedef enum logic {
      K_OPER,
      K_INSTR
   } kind_t;

   state_t                 state_q, state_d;
   kind_t                  kind_q, kind_d;
   logic [PC_WIDTH-1:0]    addr_q, addr_d;
   logic [BUS_WIDTH-1:0]   ir_q, ir_d;
   logic [BUS_WIDTH-1:0]   operand_q, operand_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [MAR_WIDTH-1:0]   mar_q, mar_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic                   err_q, err_d;
   logic [5:0]             strb_prev_q, strb_prev_d;

`ifdef FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
   logic [TO_W-1:0]        wait_q, wait_d;
`endif

   logic [5:0] strb;
   logic [5:0] strb_rise;
   logic       read_rise, pc_rise, jump_rise, mar_rise, col_rise, row_rise;

   assign strb      = {row_inc, col_inc, mar_inc, jump, pc_inc, imem_read};
   assign strb_rise = strb & ~strb_prev_q;
   assign read_rise = strb_rise[0];
   assign pc_rise   = strb_rise[1];
   assign jump_rise = strb_rise[2];
   assign mar_rise  = strb_rise[3];
   assign col_rise  = strb_rise[4];
   assign row_rise  = strb_rise[5];

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      addr_d      = addr_q;
      ir_d        = ir_q;
      operand_d   = operand_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      row_d       = row_q;
      col_d       = col_q;
      err_d       = err_q;
      strb_prev_d = strb;
`ifdef FETCH_TIMEOUT_EN
      wait_d      = wait_q;
`endif

      if (cu_reset) begin
         state_d     = S_IDLE;
         kind_d      = K_OPER;
         addr_d      = '0;
         ir_d        = '0;
         operand_d   = '0;
         pc_d        = '0;
         mar_d       = '0;
         row_d       = '0;
         col_d       = '0;
         err_d       = 1'b0;
         strb_prev_d = '0;
`ifdef FETCH_TIMEOUT_EN
         wait_d      = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (read_rise) begin
                  state_d = S_REQ;
                  addr_d  = pc_q;
                  kind_d  = pc_inc ? K_INSTR : K_OPER;
`ifdef FETCH_TIMEOUT_EN
                  wait_d  = '0;
`endif
               end
            end
            S_REQ: begin
               if (read_rise) err_d = 1'b1;
               if (imem_ack) begin
                  if (kind_q == K_INSTR) ir_d = imem_rdata;
                  else                   operand_d = imem_rdata;
                  state_d = S_DONE;
               end
`ifdef FETCH_TIMEOUT_EN
               // wait_q counts completed REQ cycles; abort on the FETCH_TIMEOUT-th.
               else if (wait_q == TO_W'(FETCH_TIMEOUT - 1)) begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end else begin
                  wait_d = wait_q + TO_W'(1);
               end
`endif
            end
            S_DONE: begin
               if (read_rise) err_d = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         // A taken jump overrides a same-cycle increment; a not-taken one lets it through.
         if (jump_rise && !alu_zero) pc_d = operand_q[PC_WIDTH-1:0];
         else if (pc_rise)           pc_d = pc_q + PC_WIDTH'(1);

         if (mar_rise) mar_d = mar_q + MAR_WIDTH'(1);

         if (col_zero)      col_d = '0;
         else if (col_rise) col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);

         if (row_rise) row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         kind_q      <= K_OPER;
         addr_q      <= '0;
         ir_q        <= '0;
         operand_q   <= '0;
         pc_q        <= '0;
         mar_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         err_q       <= 1'b0;
         strb_prev_q <= '0;
`ifdef FETCH_TIMEOUT_EN
         wait_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         addr_q      <= addr_d;
         ir_q        <= ir_d;
         operand_q   <= operand_d;
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         row_q       <= row_d;
         col_q       <= col_d;
         err_q       <= err_d;
         strb_prev_q <= strb_prev_d;
`ifdef FETCH_TIMEOUT_EN
         wait_q      <= wait_d;
`endif
      end
   end

   assign imem_req  = (state_q == S_REQ);
   assign busy      = (state_q != S_IDLE);
   assign imem_addr = addr_q;
   assign ir        = ir_q;
   assign operand   = operand_q;
   assign pc        = pc_q;
   assign mar       = mar_q;
   assign row       = row_q;
   assign col       = col_q;
   assign fetch_err = err_q;
   assign dmem_addr = DA_W'(row_q) * DA_W'(COLS) + DA_W'(col_q);

endmodule

// File: tb/tb_fetch_agu.sv
// Self-checking bench for fetch_agu: fetch scoreboard, counter vector table, corner-case sequences.
module tb_fetch_agu;

   logic        clk = 1'b0;
   logic        reset_n, cu_reset, imem_read, pc_inc, jump, alu_zero;
   logic        mar_inc, col_inc, row_inc, col_zero;
   logic        imem_req, imem_ack, busy, fetch_err;
   logic [7:0]  imem_addr, pc, mar, dmem_addr;
   logic [15:0] imem_rdata, ir, operand;
   logic [3:0]  row, col;

   always #5 clk = ~clk;

   fetch_agu #(
      .BUS_WIDTH(16),
      .PC_WIDTH (8),
      .MAR_WIDTH(8),
      .ROWS     (16),
      .COLS     (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cu_reset  (cu_reset),
      .imem_read (imem_read),
      .pc_inc    (pc_inc),
      .jump      (jump),
      .alu_zero  (alu_zero),
      .mar_inc   (mar_inc),
      .col_inc   (col_inc),
      .row_inc   (row_inc),
      .col_zero  (col_zero),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .imem_ack  (imem_ack),
      .ir        (ir),
      .operand   (operand),
      .pc        (pc),
      .mar       (mar),
      .row       (row),
      .col       (col),
      .dmem_addr (dmem_addr),
      .busy      (busy),
      .fetch_err (fetch_err)
   );

   typedef struct {
      bit         instr;
      logic [15:0] data;
      logic [7:0]  addr;
   } fetch_t;

   typedef struct {
      bit ci, ri, cz, mi;
      int er, ec, ed, em;
   } vec_t;

   fetch_t      sb[$];
   vec_t        tbl[7];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  m_pc = '0;
   logic [15:0] m_ir = '0;
   logic [15:0] m_op = '0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic start_fetch(input bit instr, input logic [15:0] data);
      fetch_t e;
      e.instr = instr;
      e.data  = data;
      e.addr  = m_pc;
      sb.push_back(e);
      imem_read = 1'b1;
      pc_inc    = instr;
      step();
      imem_read = 1'b0;
      pc_inc    = 1'b0;
      if (instr) m_pc = m_pc + 8'd1;
      chk("req_rise", 32'(imem_req), 1);
      chk("busy_rise", 32'(busy), 1);
      chk("req_addr", 32'(imem_addr), 32'(e.addr));
      chk("pc_at_req", 32'(pc), 32'(m_pc));
   endtask

   task automatic finish_fetch(input int delay);
      fetch_t e;
      int     n;
      e = sb.pop_front();
      for (int i = 1; i < delay; i++) begin
         step();
         chk("req_hold", 32'(imem_req), 1);
         chk("addr_hold", 32'(imem_addr), 32'(e.addr));
      end
      imem_rdata = e.data;
      imem_ack   = 1'b1;
      step();
      imem_ack   = 1'b0;
      imem_rdata = '0;
      n = 0;
      while (busy && n < 10) begin
         step();
         n++;
      end
      chk("busy_done", 32'(busy), 0);
      if (e.instr) m_ir = e.data;
      else         m_op = e.data;
      chk("ir", 32'(ir), 32'(m_ir));
      chk("operand", 32'(operand), 32'(m_op));
      chk("req_drop", 32'(imem_req), 0);
   endtask

   task automatic counters(input bit ci, input bit ri, input bit cz, input bit mi);
      col_inc  = ci;
      row_inc  = ri;
      col_zero = cz;
      mar_inc  = mi;
      step();
      col_inc  = 1'b0;
      row_inc  = 1'b0;
      col_zero = 1'b0;
      mar_inc  = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, required finish before 300us");
      $fatal(1);
   end

   initial begin
      // Starting point row=1 col=0 mar=0 (after the hand-written matrix walk).
      tbl[0] = '{1, 0, 0, 0, 1, 1, 17, 0};
      tbl[1] = '{1, 0, 1, 0, 1, 0, 16, 0};
      tbl[2] = '{0, 0, 0, 1, 1, 0, 16, 1};
      tbl[3] = '{1, 1, 0, 1, 2, 1, 33, 2};
      tbl[4] = '{0, 0, 1, 0, 2, 0, 32, 2};
      tbl[5] = '{0, 1, 0, 0, 3, 0, 48, 2};
      tbl[6] = '{0, 0, 0, 0, 3, 0, 48, 2};

      reset_n = 1'b0; cu_reset = 1'b0; imem_read = 1'b0; pc_inc = 1'b0;
      jump = 1'b0; alu_zero = 1'b0; mar_inc = 1'b0; col_inc = 1'b0;
      row_inc = 1'b0; col_zero = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("rst_pc", 32'(pc), 0);
      chk("rst_ir", 32'(ir), 0);
      chk("rst_operand", 32'(operand), 0);
      chk("rst_mar", 32'(mar), 0);
      chk("rst_row", 32'(row), 0);
      chk("rst_col", 32'(col), 0);
      chk("rst_dmem", 32'(dmem_addr), 0);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(fetch_err), 0);

      // INSTR fetch with pc_inc, then OPER fetch.
      start_fetch(1'b1, 16'h2A5C);
      finish_fetch(2);
      chk("instr_pc", 32'(pc), 32'h01);
      start_fetch(1'b0, 16'h0037);
      finish_fetch(2);

      // Jump taken / not taken, and jump racing pc_inc.
      jump = 1'b1; step(); jump = 1'b0;
      chk("jump_taken", 32'(pc), 32'h37);
      step();
      jump = 1'b1; alu_zero = 1'b1; step(); jump = 1'b0; alu_zero = 1'b0;
      chk("jump_not_taken", 32'(pc), 32'h37);
      step();
      pc_inc = 1'b1; step(); pc_inc = 1'b0;
      chk("pc_inc", 32'(pc), 32'h38);
      step();
      jump = 1'b1; pc_inc = 1'b1; step(); jump = 1'b0; pc_inc = 1'b0;
      chk("jump_beats_inc", 32'(pc), 32'h37);
      step();
      jump = 1'b1; pc_inc = 1'b1; alu_zero = 1'b1; step();
      jump = 1'b0; pc_inc = 1'b0; alu_zero = 1'b0;
      chk("inc_when_not_taken", 32'(pc), 32'h38);
      step();
      m_pc = 8'h38;

      // Held pc_inc from 0xFF wraps exactly once.
      start_fetch(1'b0, 16'h00FF);
      finish_fetch(2);
      jump = 1'b1; step(); jump = 1'b0;
      chk("pc_ff", 32'(pc), 32'hFF);
      step();
      pc_inc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("held_inc", 32'(pc), 32'h00);
      end
      pc_inc = 1'b0;
      step();
      chk("held_release", 32'(pc), 32'h00);
      m_pc = 8'h00;

      // Matrix walk: 15 columns, then row_inc + col_zero together.
      for (int i = 0; i < 15; i++) begin
         counters(1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      chk("walk_col", 32'(col), 15);
      chk("walk_row", 32'(row), 0);
      chk("walk_dmem", 32'(dmem_addr), 15);
      counters(1'b0, 1'b1, 1'b1, 1'b0);
      chk("nextrow_row", 32'(row), 1);
      chk("nextrow_col", 32'(col), 0);
      chk("nextrow_dmem", 32'(dmem_addr), 16);
      step();

      foreach (tbl[i]) begin
         counters(tbl[i].ci, tbl[i].ri, tbl[i].cz, tbl[i].mi);
         chk($sformatf("vec%0d_row", i), 32'(row), tbl[i].er);
         chk($sformatf("vec%0d_col", i), 32'(col), tbl[i].ec);
         chk($sformatf("vec%0d_dmem", i), 32'(dmem_addr), tbl[i].ed);
         chk($sformatf("vec%0d_mar", i), 32'(mar), tbl[i].em);
         step();
      end

      // Column wrap does not carry into row; row and MAR wrap.
      for (int i = 0; i < 16; i++) begin
         counters(1'b1, 1'b0, 1'b0, 1'b0);
         step();
      end
      chk("col_wrap", 32'(col), 0);
      chk("col_wrap_row", 32'(row), 3);
      for (int i = 0; i < 12; i++) begin
         counters(1'b0, 1'b1, 1'b0, 1'b0);
         step();
      end
      chk("row_max_dmem", 32'(dmem_addr), 240);
      counters(1'b0, 1'b1, 1'b0, 1'b0);
      chk("row_wrap", 32'(row), 0);
      step();
      for (int i = 0; i < 253; i++) begin
         counters(1'b0, 1'b0, 1'b0, 1'b1);
         step();
      end
      chk("mar_max", 32'(mar), 32'hFF);
      counters(1'b0, 1'b0, 1'b0, 1'b1);
      chk("mar_wrap", 32'(mar), 0);
      step();

      // Overlapping imem_read while a request is outstanding.
      start_fetch(1'b0, 16'h1234);
      step();
      imem_read = 1'b1; step(); imem_read = 1'b0;
      chk("overlap_err", 32'(fetch_err), 1);
      chk("overlap_req", 32'(imem_req), 1);
      chk("overlap_addr", 32'(imem_addr), 0);
      finish_fetch(1);
      chk("err_sticky", 32'(fetch_err), 1);

      // cu_reset mid-REQ, then a stray ack in IDLE.
      start_fetch(1'b1, 16'h5555);
      cu_reset = 1'b1; step(); cu_reset = 1'b0;
      sb.delete();
      m_pc = '0; m_ir = '0; m_op = '0;
      chk("cures_req", 32'(imem_req), 0);
      chk("cures_pc", 32'(pc), 0);
      chk("cures_err", 32'(fetch_err), 0);
      chk("cures_busy", 32'(busy), 0);
      chk("cures_ir", 32'(ir), 0);
      imem_rdata = 16'hBEEF; imem_ack = 1'b1; step(); imem_ack = 1'b0; imem_rdata = '0;
      step();
      chk("idle_ack_ir", 32'(ir), 0);
      chk("idle_ack_op", 32'(operand), 0);
      chk("idle_ack_busy", 32'(busy), 0);

      // Asynchronous reset mid-REQ.
      start_fetch(1'b0, 16'h7777);
      #2 reset_n = 1'b0;
      #1;
      chk("areset_req", 32'(imem_req), 0);
      chk("areset_busy", 32'(busy), 0);
      #2 reset_n = 1'b1;
      sb.delete();
      step();

`ifdef FETCH_TIMEOUT_EN
      begin
         int n;
         start_fetch(1'b0, 16'hA0A0);
         n = 1;
         while (imem_req && n < 40) begin
            step();
            if (imem_req) n++;
         end
         void'(sb.pop_front());
         chk("timeout_cycles", 32'(n), 15);
         chk("timeout_err", 32'(fetch_err), 1);
         chk("timeout_busy", 32'(busy), 0);
         chk("timeout_operand", 32'(operand), 32'(m_op));
         chk("timeout_ir", 32'(ir), 32'(m_ir));
      end
`else
      start_fetch(1'b0, 16'hA0A0);
      repeat (40) step();
      chk("long_wait_req", 32'(imem_req), 1);
      chk("long_wait_busy", 32'(busy), 1);
      finish_fetch(1);
      chk("long_wait_err", 32'(fetch_err), 0);
`endif

      start_fetch(1'b1, 16'h0F0F);
      finish_fetch(3);
      chk("final_pc", 32'(pc), 32'(m_pc));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
